// File: rtl/or1k_vector_stub_mem_pkg.sv
// or1k_vector_stub_pkg: shared constants and types for the OR1K exception-vector
// stub slave.
//   OPC_L_J / L_NOP_WORD       : instruction encodings emitted into vector slots
//   CTI_* / BTE_LINEAR         : Wishbone B3 burst cycle-type and burst-type codes
//   stub_state_e               : bus FSM states
package or1k_vector_stub_pkg;

    localparam logic [5:0]  OPC_L_J     = 6'b000000;
    localparam logic [31:0] L_NOP_WORD  = 32'h15000000;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_EOB     = 3'b111;
    localparam logic [1:0]  BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT,
        BURST
    } stub_state_e;

endpackage

// File: rtl/or1k_vector_stub_mem_if.sv
// or1k_vector_stub_mem_if: Wishbone B3 bus bundle between an instruction fetch
// master and the vector stub slave.
//   master modport : drives adr/dat_i/sel/we/cyc/stb/cti/bte, receives dat_o/ack/err
//   slave modport  : the mirror image
interface or1k_vector_stub_mem_if #(
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [3:0]            wb_sel_i;
    logic                  wb_we_i;
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic [2:0]            wb_cti_i;
    logic [1:0]            wb_bte_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/or1k_vector_stub_mem_gen.sv
// or1k_vector_stub_gen: combinational stub-word generator.
//   adr       in  : byte address inside the vector region (low 2 bits ignored)
//   base      in  : byte address of the relocated handler table
//   word      out : l.j to the relocated handler for slot word 0, l.nop otherwise,
//                   zero when the vector is out of range
//   range_err out : vector number >= NUM_VECTORS
module or1k_vector_stub_gen
    import or1k_vector_stub_pkg::*;
#(
    parameter int ADDR_WIDTH    = 13,
    parameter int VECTOR_STRIDE = 3,
    parameter int SLOT_BITS     = 8,
    parameter int NUM_VECTORS   = 32
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [31:0]           base,
    output logic [31:0]           word,
    output logic                  range_err
);
    localparam int VEC_BITS = ADDR_WIDTH - SLOT_BITS;

    logic [VEC_BITS-1:0] vec;
    logic [31:0]         target;
    logic [31:0]         slot_start;
    logic [31:0]         off;
    logic                unused_bits;

    assign vec        = adr[ADDR_WIDTH-1:SLOT_BITS];
    assign target     = base + (32'(vec) << VECTOR_STRIDE);
    // l.j is PC-relative to the jump itself, which always sits at the slot start.
    assign slot_start = 32'(vec) << SLOT_BITS;
    assign off        = target - slot_start;
    assign range_err  = 32'(vec) >= 32'(NUM_VECTORS);

    always_comb begin
        word = L_NOP_WORD;
        if (range_err) begin
            word = '0;
        end else if (adr[SLOT_BITS-1:2] == '0) begin
            word = {OPC_L_J, off[27:2]};
        end
    end

    assign unused_bits = &{1'b0, adr[1:0], off[31:28], off[1:0]};

endmodule

// File: rtl/or1k_vector_stub_mem.sv
// or1k_vector_stub_mem: Wishbone B3 slave that synthesises OR1K exception-vector
// stubs (l.j to relocated handler + l.nop fill) with no storage array.
// Registered ack/err/data, WAIT_STATES wait cycles before the first beat,
// linear incrementing bursts, err for vectors >= NUM_VECTORS.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : Wishbone slave modport (or1k_vector_stub_mem_if)
// Build option OR1K_VECTOR_STUB_RUNTIME_BASE_EN: word address 0 becomes a
// byte-writable base register (reset VECTOR_BASE) used in place of the constant.
//
// state | meaning
// IDLE  | no transfer; accepts a new request once ack/err of the last one is gone
// WAIT  | counting down wait states before the first beat
// BEAT  | first beat: registers ack/err + data; decides whether a burst follows
// BURST | back-to-back beats at incrementing addresses
module or1k_vector_stub_mem
    import or1k_vector_stub_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE   = 32'h00002000,
    parameter int          VECTOR_STRIDE = 3,
    parameter int          ADDR_WIDTH    = 13,
    parameter int          SLOT_BITS     = 8,
    parameter int          NUM_VECTORS   = 32,
    parameter int          WAIT_STATES   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    or1k_vector_stub_mem_if.slave  bus
);
    localparam logic [3:0]            WAIT_CNT = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] WORD_INC = ADDR_WIDTH'(4);

    stub_state_e           state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] adr_q, adr_next;
    logic                  ack_next, err_next;
    logic [31:0]           dat_next;
    logic                  beat;
    logic                  req;
    logic                  burst_go;
    logic                  burst_end;
    logic [31:0]           base;
    logic [31:0]           gen_word;
    logic [31:0]           rd_word;
    logic                  gen_err;

    or1k_vector_stub_gen #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .VECTOR_STRIDE (VECTOR_STRIDE),
        .SLOT_BITS     (SLOT_BITS),
        .NUM_VECTORS   (NUM_VECTORS)
    ) u_gen (
        .adr       (adr_q),
        .base      (base),
        .word      (gen_word),
        .range_err (gen_err)
    );

    assign req       = bus.wb_cyc_i & bus.wb_stb_i;
    assign burst_go  = (bus.wb_cti_i == CTI_INCR) && (bus.wb_bte_i == BTE_LINEAR);
    assign burst_end = (bus.wb_cti_i == CTI_EOB) || (bus.wb_cti_i == CTI_CLASSIC) ||
                       (bus.wb_bte_i != BTE_LINEAR);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        adr_next   = adr_q;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                // Outputs are registered, so the master still shows the finished
                // request while ack/err is high; don't take it as a new one.
                if (req && !bus.wb_ack_o && !bus.wb_err_o) begin
                    adr_next   = {bus.wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
                    cnt_next   = WAIT_CNT;
                    state_next = (WAIT_STATES == 0) ? BEAT : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_next = BEAT;
                    end
                end
            end
            BEAT: begin
                beat = 1'b1;
                if (!gen_err && req && burst_go) begin
                    adr_next   = adr_q + WORD_INC;
                    state_next = BURST;
                end else begin
                    state_next = IDLE;
                end
            end
            BURST: begin
                if (!req) begin
                    state_next = IDLE;
                end else begin
                    beat     = 1'b1;
                    adr_next = adr_q + WORD_INC;
                    if (gen_err || burst_end) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_next = 1'b0;
        err_next = 1'b0;
        dat_next = '0;
        if (beat) begin
            ack_next = !gen_err;
            err_next = gen_err;
            dat_next = gen_err ? 32'h0 : rd_word;
        end
    end

`ifdef OR1K_VECTOR_STUB_RUNTIME_BASE_EN
    logic [31:0] base_q;
    logic        slot0;
    logic        base_wr;

    assign slot0   = (adr_q[ADDR_WIDTH-1:2] == '0);
    assign base_wr = beat && bus.wb_we_i && !gen_err && slot0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q <= VECTOR_BASE;
        end else if (base_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wb_sel_i[i]) begin
                    base_q[8*i +: 8] <= bus.wb_dat_i[8*i +: 8];
                end
            end
        end
    end

    assign base    = base_q;
    assign rd_word = slot0 ? base_q : gen_word;
`else
    logic unused_wr;

    assign base      = VECTOR_BASE;
    assign rd_word   = gen_word;
    assign unused_wr = &{1'b0, bus.wb_dat_i, bus.wb_sel_i, bus.wb_we_i};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            adr_q        <= '0;
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            bus.wb_dat_o <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            adr_q        <= adr_next;
            bus.wb_ack_o <= ack_next;
            bus.wb_err_o <= err_next;
            bus.wb_dat_o <= dat_next;
        end
    end

endmodule

// File: tb/tb_or1k_vector_stub_mem.sv
// Directed bench for or1k_vector_stub_mem. Four instances share one stimulus:
//   0: defaults   1: VECTOR_BASE=0   2: WAIT_STATES=3   3: NUM_VECTORS=16
// Each test observes the responses of one chosen instance.
module tb_or1k_vector_stub_mem;
    import or1k_vector_stub_pkg::*;

    localparam logic [31:0] NOP = 32'h15000000;

    logic        clk;
    logic        rst;
    logic [12:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic [3:0]  ack_v;
    logic [3:0]  err_v;
    logic [31:0] dat_v [4];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        or1k_vector_stub_mem_if #(.ADDR_WIDTH(13)) bus ();

        assign bus.wb_adr_i = adr;
        assign bus.wb_dat_i = dat_w;
        assign bus.wb_sel_i = sel;
        assign bus.wb_we_i  = we;
        assign bus.wb_cyc_i = cyc;
        assign bus.wb_stb_i = stb;
        assign bus.wb_cti_i = cti;
        assign bus.wb_bte_i = bte;
        assign ack_v[g]     = bus.wb_ack_o;
        assign err_v[g]     = bus.wb_err_o;
        assign dat_v[g]     = bus.wb_dat_o;

        or1k_vector_stub_mem #(
            .VECTOR_BASE   ((g == 1) ? 32'h0 : 32'h00002000),
            .VECTOR_STRIDE (3),
            .ADDR_WIDTH    (13),
            .SLOT_BITS     (8),
            .NUM_VECTORS   ((g == 3) ? 16 : 32),
            .WAIT_STATES   ((g == 2) ? 3 : 0)
        ) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single classic transfer; latency counts clock edges after the request edge.
    task automatic single(input int d, input logic [12:0] a, input logic w, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_dat,
                          input string tag);
        int          lat;
        logic        got_ack, got_err;
        logic [31:0] got_dat;
        lat = -1; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
        @(negedge clk);
        adr = a; we = w; dat_w = wd; sel = 4'hF; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (ack_v[d] || err_v[d]) begin
                lat = i; got_ack = ack_v[d]; got_err = err_v[d]; got_dat = dat_v[d];
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " ack"}, 32'(got_ack), 32'(!exp_err));
        check({tag, " err"}, 32'(got_err), 32'(exp_err));
        if (!w) check({tag, " dat"}, got_dat, exp_dat);
        @(negedge clk);
        check({tag, " one_cycle"}, {30'b0, ack_v[d], err_v[d]}, 32'h0);
    endtask

    // Burst: seq[3n +: 3] is the cti presented while beat n is being produced.
    // drop_beat >= 0 lowers stb before that beat; otherwise cyc drops after the
    // last expected response.
    task automatic burst(input int d, input logic [12:0] a, input logic [1:0] bte_val,
                         input logic [11:0] seq, input int drop_beat, input int exp_beats,
                         input logic exp_last_err, input logic [127:0] exp_dat, input string tag);
        int beats;
        int first;
        beats = 0; first = -1;
        @(negedge clk);
        adr = a; we = 1'b0; sel = 4'hF; bte = bte_val; cti = seq[2:0];
        cyc = 1'b1; stb = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (ack_v[d] || err_v[d]) begin
                if (beats == 0) first = j;
                if (beats < 4) begin
                    check($sformatf("%s dat%0d", tag, beats), dat_v[d], exp_dat[32*beats +: 32]);
                    check($sformatf("%s err%0d", tag, beats), 32'(err_v[d]),
                          32'(exp_last_err && (beats == exp_beats - 1)));
                end
                beats++;
                if (drop_beat < 0 && beats == exp_beats) begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
            if (j <= 4) cti = seq[3*(j-1) +: 3];
            if (j - 1 == drop_beat) stb = 1'b0;
        end
        cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        check({tag, " beats"}, beats, exp_beats);
        check({tag, " first"}, first, 2);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_resp;
        logic seen;
        rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        cti = CTI_CLASSIC; bte = BTE_LINEAR;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset%0d", d), {ack_v[d], err_v[d], dat_v[d][29:0]}, 32'h0);
        end
        rst = 1'b0;

        single(0, 13'h0200, 1'b0, 32'h0, 1, 1'b0, 32'h00000784, "rd_0200");
        single(0, 13'h0204, 1'b0, 32'h0, 1, 1'b0, NOP,          "rd_0204");
        single(0, 13'h1F00, 1'b0, 32'h0, 1, 1'b0, 32'h0000007E, "rd_1f00");
        single(1, 13'h0300, 1'b0, 32'h0, 1, 1'b0, 32'h03FFFF46, "neg_off");
        single(2, 13'h0200, 1'b0, 32'h0, 4, 1'b0, 32'h00000784, "wait3");
        single(3, 13'h1000, 1'b0, 32'h0, 1, 1'b1, 32'h0,        "oor");
        single(3, 13'h0F00, 1'b0, 32'h0, 1, 1'b0, 32'h0000045E, "last_vec");

        burst(0, 13'h0200, BTE_LINEAR, {CTI_EOB, CTI_INCR, CTI_INCR, CTI_INCR}, -1, 4, 1'b0,
              {NOP, NOP, NOP, 32'h00000784}, "burst4");
        burst(0, 13'h0200, BTE_LINEAR, {CTI_INCR, CTI_INCR, CTI_INCR, CTI_INCR}, 2, 2, 1'b0,
              {32'h0, 32'h0, NOP, 32'h00000784}, "stb_drop");
        burst(3, 13'h0FF8, BTE_LINEAR, {CTI_INCR, CTI_INCR, CTI_INCR, CTI_INCR}, -1, 3, 1'b1,
              {32'h0, 32'h0, NOP, NOP}, "burst_oor");
        burst(0, 13'h0200, 2'b01, {CTI_INCR, CTI_INCR, CTI_INCR, CTI_INCR}, -1, 1, 1'b0,
              {32'h0, 32'h0, 32'h0, 32'h00000784}, "bte_wrap");

        // cyc drops while the wait counter is still running
        @(negedge clk);
        adr = 13'h0200; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        n_resp = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_v[2] || err_v[2]) n_resp++;
        end
        check("wait_abort", n_resp, 0);

        // reset in the middle of a burst
        @(negedge clk);
        adr = 13'h0200; cti = CTI_INCR; cyc = 1'b1; stb = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ack_v[0]) seen = 1'b1;
        end
        check("rst_mid seen", 32'(seen), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid out", {ack_v[0], err_v[0], dat_v[0][29:0]}, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
        @(negedge clk);
        check("rst_mid idle", {30'b0, ack_v[0], err_v[0]}, 32'h0);

`ifdef OR1K_VECTOR_STUB_RUNTIME_BASE_EN
        single(0, 13'h0000, 1'b1, 32'h00004000, 1, 1'b0, 32'h0,        "wr_base");
        single(0, 13'h0200, 1'b0, 32'h0,        1, 1'b0, 32'h00000F84, "rt_base");
        single(0, 13'h0000, 1'b0, 32'h0,        1, 1'b0, 32'h00004000, "base_reg");
        reset_pulse();
        single(0, 13'h0200, 1'b0, 32'h0,        1, 1'b0, 32'h00000784, "base_rst");
`else
        single(0, 13'h0000, 1'b0, 32'h0,        1, 1'b0, 32'h00000800, "slot0");
        single(0, 13'h0000, 1'b1, 32'h00004000, 1, 1'b0, 32'h0,        "wr_drop");
        single(0, 13'h0200, 1'b0, 32'h0,        1, 1'b0, 32'h00000784, "after_wr");
        reset_pulse();
        single(0, 13'h0204, 1'b0, 32'h0,        1, 1'b0, NOP,          "after_rst");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
